// File: rtl/intpol2_stream_writer.sv
// Producer-side front end for the interpolator input FIFO: buffers a frame of
// valid/ready samples and issues single-cycle write strobes under almost-full backpressure.
module intpol2_stream_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  Afull_i,
    output logic                  Write_Enable_fifo_o,
    output logic [DATA_WIDTH-1:0] data_out_fifo,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  wr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         occ;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  acc_count;
    logic [LEN_WIDTH-1:0]  wr_next;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == {CW{1'b0}});
    // Uses full before any same-cycle pop, so a full FIFO refuses input even while draining.
    assign s_ready = (state == RUN) && !full && (acc_count < len);

    // Push/pop qualification; abort overrides both.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        wr_next = wr_count + 1'b1;
        if ((state == RUN) && !abort) begin
            push = s_valid && s_ready;
            pop  = !empty && !Afull_i;
        end else begin
            push = 1'b0;
            pop  = 1'b0;
        end
    end

    // Sample storage; pointers decide validity, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Frame control FSM, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            occ                 <= '0;
            len                 <= '0;
            acc_count           <= '0;
            wr_count            <= '0;
            Write_Enable_fifo_o <= 1'b0;
            data_out_fifo       <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else if (abort) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            occ                 <= '0;
            acc_count           <= '0;
            Write_Enable_fifo_o <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Write_Enable_fifo_o <= 1'b0;
                    if (start) begin
                        len       <= frame_len;
                        acc_count <= '0;
                        wr_count  <= '0;
                        if (frame_len == {LEN_WIDTH{1'b0}}) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        done <= 1'b0;
                    end
                end
                RUN: begin
                    if (push) begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        acc_count <= acc_count + 1'b1;
                    end else begin
                        wr_ptr    <= wr_ptr;
                    end
                    case ({push, pop})
                        2'b10:   occ <= occ + 1'b1;
                        2'b01:   occ <= occ - 1'b1;
                        default: occ <= occ;
                    endcase
                    if (pop) begin
                        rd_ptr              <= rd_ptr + 1'b1;
                        data_out_fifo       <= mem[rd_ptr];
                        Write_Enable_fifo_o <= 1'b1;
                        wr_count            <= wr_next;
                        if (wr_next == len) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            done  <= 1'b0;
                        end
                    end else begin
                        Write_Enable_fifo_o <= 1'b0;
                        done                <= 1'b0;
                    end
                end
                default: begin
                    state               <= IDLE;
                    Write_Enable_fifo_o <= 1'b0;
                    busy                <= 1'b0;
                    done                <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intpol2_stream_writer.sv
// Scoreboard bench for intpol2_stream_writer: accepted samples are queued and
// compared against every write strobe; frame-level counters are checked per scenario.
module tb_intpol2_stream_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_ready;
    logic        Afull_i = 1'b0;
    logic        Write_Enable_fifo_o;
    logic [31:0] data_out_fifo;
    logic        busy;
    logic        done;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          done_cnt = 0;
    int          done_strobes = 0;
    logic        done_we = 1'b0;
    int          first_acc = -1;
    int          first_we = -1;
    logic        afull_prev = 1'b0;
    logic        acc_now = 1'b0;

    logic        src_en = 1'b0;
    logic        src_sparse = 1'b0;
    logic [31:0] next_data = 32'd0;

    intpol2_stream_writer #(.DATA_WIDTH(32), .DEPTH(8), .LEN_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .frame_len           (frame_len),
        .s_valid             (s_valid),
        .s_data              (s_data),
        .s_ready             (s_ready),
        .Afull_i             (Afull_i),
        .Write_Enable_fifo_o (Write_Enable_fifo_o),
        .data_out_fifo       (data_out_fifo),
        .busy                (busy),
        .done                (done),
        .wr_count            (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        strobe_cnt   = 0;
        done_cnt     = 0;
        done_strobes = 0;
        done_we      = 1'b0;
        first_acc    = -1;
        first_we     = -1;
    endtask

    task automatic src_set(input logic en, input logic sparse, input logic [31:0] base);
        src_en = 1'b0;
        tick();
        tick();
        next_data  = base;
        src_sparse = sparse;
        src_en     = en;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start     = 1'b1;
        frame_len = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Monitor: scores strobes against the queue, then records new accepts.
    always @(negedge clk) begin
        cyc++;
        if (Write_Enable_fifo_o) begin
            strobe_cnt++;
            if (first_we < 0) first_we = cyc;
            check("no_we_after_afull", {31'd0, afull_prev}, 32'd0);
            if (sb_q.size() == 0) check("spurious_we", {31'd0, Write_Enable_fifo_o}, 32'd0);
            else check("data", data_out_fifo, sb_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_we      = Write_Enable_fifo_o;
            done_strobes = strobe_cnt;
        end
        afull_prev = Afull_i;
        acc_now    = s_valid && s_ready && !rst && !abort;
        if (rst || abort) begin
            sb_q.delete();
        end else if (acc_now) begin
            sb_q.push_back(s_data);
            if (first_acc < 0) first_acc = cyc;
        end
    end

    // Source model: holds each word until it is accepted.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc_now) next_data = next_data + 32'd1;
            if (!src_en) s_valid = 1'b0;
            else if (src_sparse) s_valid = !s_valid;
            else s_valid = 1'b1;
            s_data = next_data;
        end
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_we", {31'd0, Write_Enable_fifo_o}, 32'd0);
        check("rst_data", data_out_fifo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        tick();

        // Basic frame
        src_set(1'b1, 1'b0, 32'h10);
        clr();
        pulse_start(16'd4);
        wait_done(60);
        check("basic_done_cnt", done_cnt, 32'd1);
        check("basic_done_with_we", {31'd0, done_we}, 32'd1);
        check("basic_done_at_4th", done_strobes, 32'd4);
        check("basic_latency", first_we - first_acc, 32'd2);
        check("basic_wr_count", {16'd0, wr_count}, 32'd4);
        @(negedge clk);
        check("basic_busy_after", {31'd0, busy}, 32'd0);
        tick();
        check("basic_strobes", strobe_cnt, 32'd4);

        // Backpressure
        src_set(1'b1, 1'b0, 32'h100);
        clr();
        pulse_start(16'd16);
        repeat (3) tick();
        Afull_i = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("bp_full_s_ready", {31'd0, s_ready}, 32'd0);
        check("bp_buffered", sb_q.size(), 32'd8);
        tick();
        Afull_i = 1'b0;
        wait_done(100);
        repeat (3) tick();
        check("bp_done_cnt", done_cnt, 32'd1);
        check("bp_strobes", strobe_cnt, 32'd16);
        check("bp_wr_count", {16'd0, wr_count}, 32'd16);
        check("bp_sb_empty", sb_q.size(), 32'd0);

        // Zero-length frame
        src_set(1'b0, 1'b0, 32'h0);
        clr();
        pulse_start(16'd0);
        @(negedge clk);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        check("zero_done_cnt", done_cnt, 32'd1);
        check("zero_strobes", strobe_cnt, 32'd0);

        // Abort with words buffered
        Afull_i = 1'b1;
        src_set(1'b1, 1'b0, 32'h200);
        clr();
        pulse_start(16'd20);
        begin
            int n = 0;
            while (sb_q.size() < 8 && n < 60) begin tick(); n++; end
        end
        src_en  = 1'b0;
        tick();
        Afull_i = 1'b0;
        begin
            int n = 0;
            while (strobe_cnt < 4 && n < 60) begin tick(); n++; end
        end
        Afull_i = 1'b1;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        Afull_i = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_we", {31'd0, Write_Enable_fifo_o}, 32'd0);
        check("abort_s_ready", {31'd0, s_ready}, 32'd0);
        check("abort_wr_count", {16'd0, wr_count}, 32'd5);
        repeat (6) tick();
        check("abort_strobes", strobe_cnt, 32'd5);
        check("abort_no_done", done_cnt, 32'd0);
        src_set(1'b1, 1'b0, 32'h300);
        clr();
        pulse_start(16'd2);
        wait_done(60);
        repeat (2) tick();
        check("post_abort_strobes", strobe_cnt, 32'd2);
        check("post_abort_wr_count", {16'd0, wr_count}, 32'd2);

        // Sparse source, start re-pulsed while busy
        for (int r = 0; r < 2; r++) begin
            src_set(1'b1, 1'b1, 32'h400 + 32'h10 * r);
            clr();
            pulse_start(16'd3);
            tick();
            pulse_start(16'd9);
            wait_done(80);
            repeat (6) tick();
            check("sparse_done_cnt", done_cnt, 32'd1);
            check("sparse_strobes", strobe_cnt, 32'd3);
            check("sparse_wr_count", {16'd0, wr_count}, 32'd3);
        end

        // Reset mid-frame
        src_set(1'b1, 1'b0, 32'h500);
        clr();
        pulse_start(16'd10);
        begin
            int n = 0;
            while (strobe_cnt < 3 && n < 60) begin tick(); n++; end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_we", {31'd0, Write_Enable_fifo_o}, 32'd0);
        check("mrst_data", data_out_fifo, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mrst_wr_count", {16'd0, wr_count}, 32'd0);
        clr();
        repeat (10) tick();
        check("mrst_no_stale", strobe_cnt, 32'd0);
        src_set(1'b1, 1'b0, 32'h600);
        pulse_start(16'd2);
        wait_done(60);
        repeat (2) tick();
        check("mrst_next_strobes", strobe_cnt, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intpol2_stream_writer.md
Name: intpol2_stream_writer

Overview:
- Producer-side front end that feeds the interpolator's input sample FIFO port.
- Accepts frames of samples from a valid/ready source and buffers them in a small internal FIFO.
- Issues single-cycle write strobes with data toward the interpolator, and honours the interpolator's almost-full backpressure.
- Sits between the sample source (DMA/ADC capture) and the interpolator's Write_Enable_fifo_i / data_in_fifo / Afull_o pins.

Parameters:
- DATA_WIDTH, 32, width of one sample word.
- DEPTH, 8, internal FIFO depth in words; power of 2, minimum 2.
- LEN_WIDTH, 16, width of the frame-length and count fields.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- abort  in  1  synchronous frame abort; honoured in any state.
- frame_len  in  LEN_WIDTH  number of samples in the frame; sampled on an accepted start.
- s_valid  in  1  source data valid.
- s_data  in  DATA_WIDTH  source sample.
- s_ready  out  1  writer can accept s_data this cycle.
- Afull_i  in  1  interpolator input FIFO almost full (driven from the interpolator's Afull_o).
- Write_Enable_fifo_o  out  1  one-cycle write strobe to the interpolator.
- data_out_fifo  out  DATA_WIDTH  sample qualified by Write_Enable_fifo_o.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the last sample of a frame is written out.
- wr_count  out  LEN_WIDTH  samples written to the interpolator in the current/last frame.

Behaviour:
- Reset: state=IDLE, FIFO empty, both counters 0, latched length 0. Outputs at reset: s_ready=0, Write_Enable_fifo_o=0, data_out_fifo=0, busy=0, done=0, wr_count=0.
- Clock and reset are fixed as stated: one clock (clk); reset (rst) is synchronous and active-high.
- FSM IDLE:
  - start=1 latches frame_len, clears acc_count and wr_count, goes to RUN.
  - If frame_len=0, it instead pulses done on the next cycle and stays in IDLE; no writes are issued.
- FSM RUN:
  - Push: s_ready = !full && acc_count<len. A push occurs when s_valid&&s_ready, and acc_count increments.
  - Pop: when the FIFO is not empty and Afull_i=0 in the current cycle, pop the head. On the next edge register the word into data_out_fifo with Write_Enable_fifo_o=1; otherwise Write_Enable_fifo_o=0 and data_out_fifo holds its value.
  - Each strobe increments wr_count. When the strobe that brings wr_count to len is issued, assert done in the same cycle as that strobe and go to IDLE.
- Latency: a sample accepted at edge k appears with Write_Enable_fifo_o high in the cycle after edge k+1 (2 cycles), provided Afull_i=0 at cycle k+1 and the FIFO was empty.
- Backpressure: Write_Enable_fifo_o is never high in a cycle whose preceding cycle had Afull_i=1. The FIFO and the source stall with no loss and no duplication.
- Simultaneous push and pop: allowed in the same cycle, including at full. s_ready is computed from full before the pop, so a full FIFO refuses input even while popping. Occupancy stays in range 0..DEPTH.
- Pointers wrap modulo DEPTH; occupancy counter width is log2(DEPTH)+1.
- start while in RUN is ignored. Source data offered after acc_count reaches len is not accepted (s_ready=0).
- abort (any state, priority over start and push/pop):
  - Next edge: FIFO flushed, state=IDLE, Write_Enable_fifo_o=0, no done pulse.
  - wr_count holds its last value.
- rst mid-frame: identical to reset values next edge; a write strobe in flight is dropped.
- done and busy are registered. busy=1 exactly while in RUN.

Test Plan:
- Basic frame: frame_len=4, s_valid held high with data 0x10..0x13, Afull_i=0 -> four consecutive strobes carrying 0x10,0x11,0x12,0x13; first strobe 2 cycles after first accept; done coincident with 4th strobe; wr_count=4; busy falls the next cycle.
- Backpressure: frame_len=16, continuous source, Afull_i high for 10 cycles mid-frame -> no strobe in the cycle after any Afull_i=1 cycle; s_ready drops once 8 words are buffered; all 16 words delivered in order, none duplicated; done once.
- Zero-length frame: start with frame_len=0 -> done pulse next cycle, no strobe, busy stays 0.
- Abort: frame_len=20, abort after 5 strobes with 3 words buffered -> next cycle IDLE, FIFO empty, no strobes, no done; wr_count=5; a following frame_len=2 runs cleanly.
- Sparse source with restart: s_valid toggling every other cycle, frame_len=3, start re-pulsed while busy -> second start ignored; exactly 3 strobes; after done, a new start is accepted and repeats the behaviour.
- Reset mid-frame: rst asserted for 1 cycle during RUN -> all outputs at reset values the next cycle; no stale data emitted afterwards.
